// File: rtl/gpu_pkg.sv
// Shared writeback definitions.
//   RZ_ADDR / PT_PRED : "no destination" encodings for register and predicate fields
//   wb_entry_t        : one buffered SP result {data, addr, pre, lane, is_pc}
//   wb_state_e        : completion tracker states
package gpu_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 9;
  localparam int unsigned WB_PRED_W = 3;
  localparam int unsigned WB_LANE_W = 5;

  // All-ones destinations mean "do not write".
  localparam logic [WB_ADDR_W-1:0] RZ_ADDR = '1;
  localparam logic [WB_PRED_W-1:0] PT_PRED = '1;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_PRED_W-1:0] pre;
    logic [WB_LANE_W-1:0] lane;
    logic                 is_pc;
  } wb_entry_t;

  typedef enum logic [0:0] {
    WB_IDLE,
    WB_WAIT
  } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries with the head read straight from registered storage.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous flush (wins over push/pop)
//   push_i        : write entry_i at the tail
//   pop_i         : retire the head (ignored when empty)
//   push_ok_o     : push accepted this cycle (not full, or full with a simultaneous pop)
//   full_o/empty_o: occupancy flags
//   count_o       : occupancy, $clog2(DEPTH)+1 bits
//   head_o        : oldest entry; meaningful only while !empty_o
module wb_fifo
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  wb_entry_t                entry_i,
  input  logic                     pop_i,
  output logic                     push_ok_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output wb_entry_t                head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t        mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             pop_ok;

  assign full_o    = (count_q == CntW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign pop_ok    = pop_i && !empty_o;
  // A full buffer can still take a push when the head leaves in the same cycle.
  assign push_ok_o = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_o) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)    rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_ok_o) - CntW'(pop_ok);
    end
  end

  // Storage needs no reset: consumers gate every field with !empty_o.
  always_ff @(posedge clk_i) begin
    if (push_ok_o && !clr_i) mem[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sp_wb.sv
// Writeback stage behind the SP execution unit.
// Buffers per-lane results and retires them in order as register writes, predicate writes or
// PC redirects; pulses wb_done once every result ahead of sp_ack has retired.
//   clk, Resetn     : clock, asynchronous active-low reset
//   clr             : synchronous flush of buffer and tracker (err is kept)
//   sp_*            : result stream from the SP, sp_stall is registered back-pressure
//   rf_*            : register-file write port, held until rf_ready
//   pr_*            : predicate write, strobed once in the retire cycle
//   pc_req/pc_target: branch redirect pulse
//   wb_done         : completion pulse, err: sticky protocol error
module sp_wb
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned ADDR_W = WB_ADDR_W,
  parameter int unsigned PRED_W = WB_PRED_W,
  parameter int unsigned LANE_W = WB_LANE_W
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              clr,
  input  logic              sp_outen,
  input  logic [DATA_W-1:0] sp_out,
  input  logic [ADDR_W-1:0] sp_des_addr,
  input  logic [PRED_W-1:0] sp_des_pre,
  input  logic [LANE_W-1:0] sp_cnt,
  input  logic              sp_set_pc_req,
  input  logic              sp_ack,
  output logic              sp_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [LANE_W-1:0] rf_wlane,
  input  logic              rf_ready,
  output logic              pr_we,
  output logic [PRED_W-1:0] pr_waddr,
  output logic              pr_wdata,
  output logic [LANE_W-1:0] pr_wlane,
  output logic              pc_req,
  output logic [DATA_W-1:0] pc_target,
  output logic              wb_done,
  output logic              err
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  wb_entry_t       push_entry, head;
  logic            full, empty, valid;
  logic            push, pop, push_ok;
  logic            rf_need, pr_need;
  logic [CntW-1:0] count, occ_next;

  wb_state_e       state_q, state_d;
  logic [CntW-1:0] done_cnt_q, done_cnt_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            stall_q;

  assign push_entry = '{data: sp_out, addr: sp_des_addr, pre: sp_des_pre,
                        lane: sp_cnt, is_pc: sp_set_pc_req};

  assign valid   = !empty;
  assign rf_need = (head.addr != RZ_ADDR);
  assign pr_need = (head.pre != PT_PRED);
  assign push    = sp_outen && !clr;
  // Branches and predicate-only results never wait on the register file.
  assign pop     = valid && !clr && (head.is_pc || !rf_need || rf_ready);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (Resetn),
    .clr_i     (clr),
    .push_i    (push),
    .entry_i   (push_entry),
    .pop_i     (pop),
    .push_ok_o (push_ok),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count),
    .head_o    (head)
  );

  // Occupancy as it will be at the end of this cycle.
  assign occ_next = clr ? '0 : count + CntW'(push_ok) - CntW'(pop);

  // State register.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= WB_IDLE;
      done_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_cnt_q <= done_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      stall_q    <= (occ_next >= CntW'(DEPTH - 1));
    end
  end

  // Next-state logic for the completion tracker and error flag.
  always_comb begin
    state_d    = state_q;
    done_cnt_d = done_cnt_q;
    done_d     = 1'b0;
    err_d      = err_q | (push && full && !pop) | (sp_ack && (state_q == WB_WAIT));
    if (clr) begin
      state_d    = WB_IDLE;
      done_cnt_d = '0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          if (sp_ack) begin
            if (occ_next == '0) begin
              done_d = 1'b1;
            end else begin
              done_cnt_d = occ_next;
              state_d    = WB_WAIT;
            end
          end
        end
        WB_WAIT: begin
          // Retirement is in order, so every pop belongs to the tracked instruction.
          if (pop) begin
            done_cnt_d = done_cnt_q - CntW'(1);
            if (done_cnt_q == CntW'(1)) begin
              done_d  = 1'b1;
              state_d = WB_IDLE;
            end
          end
        end
        default: state_d = WB_IDLE;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    rf_we     = valid && !clr && !head.is_pc && rf_need;
    pr_we     = pop && !head.is_pc && pr_need;
    pc_req    = valid && !clr && head.is_pc;
    rf_waddr  = valid ? head.addr : '0;
    rf_wdata  = valid ? head.data : '0;
    rf_wlane  = valid ? head.lane : '0;
    pr_waddr  = valid ? head.pre : '0;
    pr_wdata  = valid && head.data[0];
    pr_wlane  = valid ? head.lane : '0;
    pc_target = valid ? head.data : '0;
    wb_done   = done_q && !clr;
    sp_stall  = stall_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_sp_wb.sv
// Directed bench for sp_wb: reset, single write, predicate, branch, burst/back-pressure,
// completion tracking, flush and mid-run reset.
module tb_sp_wb;

  logic        clk = 1'b0;
  logic        Resetn, clr, sp_outen, sp_set_pc_req, sp_ack, rf_ready;
  logic [31:0] sp_out;
  logic [8:0]  sp_des_addr;
  logic [2:0]  sp_des_pre;
  logic [4:0]  sp_cnt;
  logic        sp_stall, rf_we, pr_we, pr_wdata, pc_req, wb_done, err;
  logic [8:0]  rf_waddr;
  logic [31:0] rf_wdata, pc_target;
  logic [4:0]  rf_wlane, pr_wlane;
  logic [2:0]  pr_waddr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sp_wb dut (
    .clk           (clk),
    .Resetn        (Resetn),
    .clr           (clr),
    .sp_outen      (sp_outen),
    .sp_out        (sp_out),
    .sp_des_addr   (sp_des_addr),
    .sp_des_pre    (sp_des_pre),
    .sp_cnt        (sp_cnt),
    .sp_set_pc_req (sp_set_pc_req),
    .sp_ack        (sp_ack),
    .sp_stall      (sp_stall),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .rf_wlane      (rf_wlane),
    .rf_ready      (rf_ready),
    .pr_we         (pr_we),
    .pr_waddr      (pr_waddr),
    .pr_wdata      (pr_wdata),
    .pr_wlane      (pr_wlane),
    .pc_req        (pc_req),
    .pc_target     (pc_target),
    .wb_done       (wb_done),
    .err           (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [8:0] a, input logic [2:0] p,
                      input logic [4:0] c, input logic is_pc);
    sp_out        = d;
    sp_des_addr   = a;
    sp_des_pre    = p;
    sp_cnt        = c;
    sp_set_pc_req = is_pc;
    sp_outen      = 1'b1;
    tick();
    sp_outen      = 1'b0;
    sp_set_pc_req = 1'b0;
    #1;
  endtask

  task automatic pulse_reset();
    Resetn = 1'b0;
    #1;
    Resetn = 1'b1;
    #1;
  endtask

  initial begin
    Resetn = 1'b0; clr = 1'b0; sp_outen = 1'b0; sp_set_pc_req = 1'b0; sp_ack = 1'b0;
    rf_ready = 1'b1; sp_out = '0; sp_des_addr = '0; sp_des_pre = '0; sp_cnt = '0;
    #12;
    chk("rst_stall", sp_stall, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pr_we", pr_we, 0);
    chk("rst_pc_req", pc_req, 0);
    chk("rst_done", wb_done, 0);
    chk("rst_err", err, 0);
    chk("rst_waddr", rf_waddr, 0);
    Resetn = 1'b1;
    tick();

    // Single register write.
    push(32'h1234, 9'd5, 3'd7, 5'd3, 1'b0);
    chk("single_we", rf_we, 1);
    chk("single_addr", rf_waddr, 5);
    chk("single_data", rf_wdata, 32'h1234);
    chk("single_lane", rf_wlane, 3);
    chk("single_no_pr", pr_we, 0);
    tick();
    chk("single_popped", rf_we, 0);

    // Register + predicate write: predicate strobes only in the accept cycle.
    rf_ready = 1'b0;
    push(32'h3, 9'd3, 3'd1, 5'd2, 1'b0);
    chk("rfpr_rf_we", rf_we, 1);
    chk("rfpr_pr_held", pr_we, 0);
    rf_ready = 1'b1;
    #1;
    chk("rfpr_pr_we", pr_we, 1);
    chk("rfpr_pr_data", pr_wdata, 1);
    chk("rfpr_pr_addr", pr_waddr, 1);
    tick();
    chk("rfpr_popped", rf_we, 0);

    // Burst with back-pressure, then overflow.
    rf_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'h100 + 32'(i), 9'(10 + i), 3'd7, 5'(i), 1'b0);
      chk("burst_head_hold", rf_waddr, 10);
      chk("burst_stall", sp_stall, 32'(i >= 2));
    end
    chk("burst_noerr", err, 0);
    push(32'h200, 9'd30, 3'd7, 5'd9, 1'b0);
    chk("overflow_err", err, 1);
    rf_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_we", rf_we, 1);
      chk("drain_addr", rf_waddr, 32'(10 + i));
      chk("drain_data", rf_wdata, 32'h100 + 32'(i));
      chk("drain_lane", rf_wlane, 32'(i));
      tick();
    end
    chk("drain_empty", rf_we, 0);
    chk("drain_stall", sp_stall, 0);
    pulse_reset();
    chk("reset_clears_err", err, 0);

    // Predicate-only result retires without rf_ready.
    rf_ready = 1'b0;
    push(32'h1, 9'h1FF, 3'd2, 5'd4, 1'b0);
    chk("pred_we", pr_we, 1);
    chk("pred_addr", pr_waddr, 2);
    chk("pred_data", pr_wdata, 1);
    chk("pred_lane", pr_wlane, 4);
    chk("pred_no_rf", rf_we, 0);
    tick();
    chk("pred_once", pr_we, 0);
    chk("pred_gone", pr_wlane, 0);

    // Branch redirect.
    push(32'h80, 9'd6, 3'd1, 5'd1, 1'b1);
    chk("pc_req", pc_req, 1);
    chk("pc_target", pc_target, 32'h80);
    chk("pc_no_rf", rf_we, 0);
    chk("pc_no_pr", pr_we, 0);
    tick();
    chk("pc_pulse", pc_req, 0);

    // Ack on an empty buffer.
    sp_ack = 1'b1;
    #1;
    chk("ack_empty_same", wb_done, 0);
    tick();
    sp_ack = 1'b0;
    #1;
    chk("ack_empty_done", wb_done, 1);
    tick();
    chk("ack_empty_pulse", wb_done, 0);

    // Ack with three pending, rf_ready toggling, second ack inside WAIT.
    for (int i = 0; i < 3; i++) push(32'h20 + 32'(i), 9'(20 + i), 3'd7, 5'(i), 1'b0);
    chk("wait_noerr", err, 0);
    sp_ack = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      rf_ready = (k % 2 == 0);
      sp_ack   = (k == 1);
      #1;
      chk("wait_no_done", wb_done, 0);
      tick();
    end
    sp_ack = 1'b0;
    rf_ready = 1'b0;
    #1;
    chk("done_pulse", wb_done, 1);
    chk("ack_in_wait_err", err, 1);
    tick();
    chk("done_single", wb_done, 0);
    chk("done_empty", rf_we, 0);

    // Flush with two pending while WAIT is active.
    push(32'h40, 9'd40, 3'd7, 5'd0, 1'b0);
    push(32'h41, 9'd41, 3'd7, 5'd1, 1'b0);
    sp_ack = 1'b1;
    tick();
    sp_ack = 1'b0;
    clr = 1'b1;
    rf_ready = 1'b1;
    #1;
    chk("clr_suppress", rf_we, 0);
    tick();
    clr = 1'b0;
    rf_ready = 1'b0;
    #1;
    chk("flush_empty", rf_we, 0);
    chk("flush_stall", sp_stall, 0);
    chk("clr_keeps_err", err, 1);
    tick();
    chk("flush_no_done", wb_done, 0);
    sp_ack = 1'b1;
    tick();
    sp_ack = 1'b0;
    #1;
    chk("flush_idle", wb_done, 1);
    clr = 1'b1;
    push(32'h55, 9'd55, 3'd7, 5'd5, 1'b0);
    clr = 1'b0;
    #1;
    chk("clr_drops_push", rf_we, 0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) push(32'h60 + 32'(i), 9'(60 + i), 3'd1, 5'(i), 1'b0);
    chk("pre_reset_stall", sp_stall, 1);
    #2;
    Resetn = 1'b0;
    #1;
    chk("mid_rst_stall", sp_stall, 0);
    chk("mid_rst_rf_we", rf_we, 0);
    chk("mid_rst_waddr", rf_waddr, 0);
    chk("mid_rst_wdata", rf_wdata, 0);
    chk("mid_rst_pr_we", pr_we, 0);
    chk("mid_rst_pc", pc_req, 0);
    chk("mid_rst_done", wb_done, 0);
    chk("mid_rst_err", err, 0);
    Resetn = 1'b1;
    tick();
    chk("post_rst_empty", rf_we, 0);
    chk("post_rst_done", wb_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
